bnb_shift_pair: RTL and testbench



---
 rtl/bnb_pkg.sv | 12 +
 rtl/bnb_stage.sv | 23 ++
 rtl/bnb_shift_pair.sv | 82 ++++++++
 tb/tb_bnb_shift_pair.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bnb_pkg.sv
// Shared constants and width helper for the bnb_shift_pair delay block.
package bnb_pkg;

  localparam int BNB_WIDTH_DEF = 1;
  localparam int BNB_DEPTH_DEF = 3;

  // Bits needed for a counter that reaches 'depth' without wrapping.
  function automatic int fill_t_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/bnb_stage.sv
// Single WIDTH-bit register with asynchronous active-high clear and enable.
module bnb_stage
  import bnb_pkg::*;
#(
  parameter int WIDTH = BNB_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Capture d on enabled edges, clear immediately on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/bnb_shift_pair.sv
// Two-path delay block: a one-register "collapsed" path (q_block) beside a
// DEPTH-stage shift chain (q_nonblock), plus a saturating fill counter.
// Optional feature: define BNB_MISMATCH_EN to add the registered 'mismatch'
// output that flags disagreement between the two paths once the chain is full.
module bnb_shift_pair
  import bnb_pkg::*;
#(
  parameter int WIDTH = BNB_WIDTH_DEF,
  parameter int DEPTH = BNB_DEPTH_DEF
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               en,
  input  logic [WIDTH-1:0]                   d,
  output logic [WIDTH-1:0]                   q_block,
  output logic [WIDTH-1:0]                   q_nonblock,
  output logic [DEPTH*WIDTH-1:0]             taps,
  output logic [fill_t_width(DEPTH)-1:0]     fill,
  output logic                               full
`ifdef BNB_MISMATCH_EN
  ,
  output logic                               mismatch
`endif
);

  localparam int FW = fill_t_width(DEPTH);
  localparam logic [FW-1:0] FILL_MAX = FW'(DEPTH);

  // Stages 0..DEPTH-1 form the chain; stage DEPTH is the block-path register.
  for (genvar k = 0; k <= DEPTH; k++) begin : g_stage
    if (k == DEPTH) begin : g_block
      bnb_stage #(.WIDTH(WIDTH)) u_stage (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .d   (d),
        .q   (q_block)
      );
    end else if (k == 0) begin : g_head
      bnb_stage #(.WIDTH(WIDTH)) u_stage (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .d   (d),
        .q   (taps[0 +: WIDTH])
      );
    end else begin : g_chain
      bnb_stage #(.WIDTH(WIDTH)) u_stage (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .d   (taps[(k-1)*WIDTH +: WIDTH]),
        .q   (taps[k*WIDTH +: WIDTH])
      );
    end
  end

  assign q_nonblock = taps[(DEPTH-1)*WIDTH +: WIDTH];

  // Count enabled edges since reset, holding at DEPTH rather than wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill <= '0;
    end else if (en && (fill != FILL_MAX)) begin
      fill <= fill + 1'b1;
    end
  end

  assign full = (fill == FILL_MAX);

`ifdef BNB_MISMATCH_EN
  // Register a disagreement flag between the two paths once the chain is full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mismatch <= 1'b0;
    end else if (en) begin
      mismatch <= (q_block != q_nonblock) && full;
    end
  end
`endif

endmodule

// File: tb/tb_bnb_shift_pair.sv
// Self-checking bench for bnb_shift_pair (default WIDTH=1, DEPTH=3).
// Define BNB_MISMATCH_EN to also exercise the mismatch output.
module tb_bnb_shift_pair;
  import bnb_pkg::*;

  localparam int WIDTH = 1;
  localparam int DEPTH = 3;
  localparam int FW    = fill_t_width(DEPTH);

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   en;
  logic [WIDTH-1:0]       d;
  logic [WIDTH-1:0]       q_block;
  logic [WIDTH-1:0]       q_nonblock;
  logic [DEPTH*WIDTH-1:0] taps;
  logic [FW-1:0]          fill;
  logic                   full;
`ifdef BNB_MISMATCH_EN
  logic                   mismatch;
`endif

  int compared   = 0;
  int mismatched = 0;

  // Reference model: newest enabled sample at index 0, count of enabled edges.
  logic [WIDTH-1:0] hist[$];
  int               cnt;
  logic             exp_mis;

  bnb_shift_pair #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .d          (d),
    .q_block    (q_block),
    .q_nonblock (q_nonblock),
    .taps       (taps),
    .fill       (fill),
    .full       (full)
`ifdef BNB_MISMATCH_EN
    ,
    .mismatch   (mismatch)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] m_tap(input int k);
    return (k < hist.size()) ? hist[k] : '0;
  endfunction

  function automatic logic [DEPTH*WIDTH-1:0] m_taps();
    logic [DEPTH*WIDTH-1:0] t;
    t = '0;
    for (int k = 0; k < DEPTH; k++) t[k*WIDTH +: WIDTH] = m_tap(k);
    return t;
  endfunction

  function automatic int m_fill();
    return (cnt < DEPTH) ? cnt : DEPTH;
  endfunction

  task automatic model_reset();
    hist.delete();
    cnt     = 0;
    exp_mis = 1'b0;
  endtask

  // Drive one cycle from a falling edge, advance the model, return at next falling edge.
  task automatic tick(input logic e, input logic [WIDTH-1:0] v);
    en = e;
    d  = v;
    @(posedge clk);
    if (e) begin
      exp_mis = (m_tap(0) != m_tap(DEPTH-1)) && (m_fill() == DEPTH);
      hist.push_front(v);
      if (hist.size() > DEPTH) void'(hist.pop_back());
      cnt++;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en  = 1'b1;
    d   = '1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en  = 1'b1;
    d   = '1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      compared++;
      if ({q_block, q_nonblock, taps, fill, full} !== '0) begin
        mismatched++;
        $display("FAIL reset_hold cyc=%0d: got qb=%b qn=%b taps=%b fill=%0d full=%b, want all 0",
                 i, q_block, q_nonblock, taps, fill, full);
      end
    end
    rst = 1'b0;
    model_reset();
    // Load some ones, then assert reset between edges.
    repeat (4) tick(1'b1, '1);
    #2 rst = 1'b1;
    #1;
    compared++;
    if ({q_block, q_nonblock, taps, fill, full} !== '0) begin
      mismatched++;
      $display("FAIL reset_async: got qb=%b qn=%b taps=%b fill=%0d full=%b, want all 0",
               q_block, q_nonblock, taps, fill, full);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_impulse();
    logic [DEPTH*WIDTH-1:0] want_taps[4];
    logic [WIDTH-1:0]       want_qb[4];
    logic [WIDTH-1:0]       want_qn[4];
    want_taps = '{3'b001, 3'b010, 3'b100, 3'b000};
    want_qb   = '{1'b1, 1'b0, 1'b0, 1'b0};
    want_qn   = '{1'b0, 1'b0, 1'b1, 1'b0};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      tick(1'b1, (i == 0) ? 1'b1 : 1'b0);
      compared++;
      if ({q_block, q_nonblock, taps} !== {want_qb[i], want_qn[i], want_taps[i]}) begin
        mismatched++;
        $display("FAIL impulse cyc=%0d: got qb=%b qn=%b taps=%b, want qb=%b qn=%b taps=%b",
                 i + 1, q_block, q_nonblock, taps, want_qb[i], want_qn[i], want_taps[i]);
      end
    end
  endtask

  task automatic test_random_stream();
    do_reset();
    for (int i = 0; i < 11; i++) begin
      tick(1'b1, WIDTH'($urandom));
      compared++;
      if ({q_block, q_nonblock, taps, fill, full} !==
          {m_tap(0), m_tap(DEPTH-1), m_taps(), FW'(m_fill()), (m_fill() == DEPTH)}) begin
        mismatched++;
        $display("FAIL random_stream n=%0d: got qb=%b qn=%b taps=%b fill=%0d full=%b, want qb=%b qn=%b taps=%b fill=%0d",
                 i + 1, q_block, q_nonblock, taps, fill, full,
                 m_tap(0), m_tap(DEPTH-1), m_taps(), m_fill());
      end
    end
  endtask

  task automatic test_enable_gating();
    logic [DEPTH*WIDTH-1:0] held_taps;
    logic [FW-1:0]          held_fill;
    logic [WIDTH-1:0]       seq[3];
    seq = '{1'b1, 1'b0, 1'b1};
    do_reset();
    for (int s = 0; s < 3; s++) begin
      tick(1'b1, seq[s]);
      held_taps = m_taps();
      held_fill = FW'(m_fill());
      if (s == 2) break;
      for (int g = 0; g < 2; g++) begin
        tick(1'b0, WIDTH'($urandom));
        compared++;
        if ({taps, fill} !== {held_taps, held_fill}) begin
          mismatched++;
          $display("FAIL enable_hold s=%0d g=%0d: got taps=%b fill=%0d, want taps=%b fill=%0d",
                   s, g, taps, fill, held_taps, held_fill);
        end
      end
    end
    compared++;
    if ({taps, fill} !== {3'b101, 2'd3}) begin
      mismatched++;
      $display("FAIL enable_final: got taps=%b fill=%0d, want taps=101 fill=3", taps, fill);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 1; i <= 10; i++) begin
      tick(1'b1, WIDTH'($urandom));
      compared++;
      if ({fill, full} !== {FW'((i < DEPTH) ? i : DEPTH), (i >= DEPTH)}) begin
        mismatched++;
        $display("FAIL saturation i=%0d: got fill=%0d full=%b, want fill=%0d full=%b",
                 i, fill, full, (i < DEPTH) ? i : DEPTH, (i >= DEPTH));
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 40; i++) begin
      tick(($urandom_range(0, 3) != 0), WIDTH'($urandom));
      compared++;
      if ({q_block, q_nonblock, taps, fill, full} !==
          {m_tap(0), m_tap(DEPTH-1), m_taps(), FW'(m_fill()), (m_fill() == DEPTH)}) begin
        mismatched++;
        $display("FAIL back_to_back i=%0d: got qb=%b qn=%b taps=%b fill=%0d, want qb=%b qn=%b taps=%b fill=%0d",
                 i, q_block, q_nonblock, taps, fill,
                 m_tap(0), m_tap(DEPTH-1), m_taps(), m_fill());
      end
    end
  endtask

`ifdef BNB_MISMATCH_EN
  task automatic test_mismatch();
    logic [WIDTH-1:0] pat[8];
    pat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    do_reset();
    compared++;
    if (mismatch !== 1'b0) begin
      mismatched++;
      $display("FAIL mismatch_reset: got %b, want 0", mismatch);
    end
    for (int i = 0; i < 8; i++) begin
      tick(1'b1, pat[i]);
      compared++;
      if (mismatch !== exp_mis) begin
        mismatched++;
        $display("FAIL mismatch i=%0d: got %b, want %b", i, mismatch, exp_mis);
      end
    end
    #2 rst = 1'b1;
    #1;
    compared++;
    if (mismatch !== 1'b0) begin
      mismatched++;
      $display("FAIL mismatch_in_reset: got %b, want 0", mismatch);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask
`endif

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    d   = '0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_impulse();
    test_random_stream();
    test_enable_gating();
    test_saturation();
    test_back_to_back();
`ifdef BNB_MISMATCH_EN
    test_mismatch();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
